// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the regfile write port among N_REQ writeback sources.
// One grant per cycle; the granted write reaches the regfile one cycle later.
module regfile_wb_pend_lane #(
  parameter int REGFILE_WIDTH = 5
) (
  input  logic                     valid_i,
  input  logic [REGFILE_WIDTH-1:0] addr_i,
  output logic [31:0]              mask_o
);
  // Bit 0 never set: x0 writes are architecturally dropped.
  always_comb begin
    mask_o = '0;
    for (int k = 1; k < 32; k++)
      if (valid_i && addr_i == REGFILE_WIDTH'(k)) mask_o[k] = 1'b1;
  end
endmodule

module regfile_wb_arbiter #(
  parameter int N_REQ         = 3,
  parameter int REGFILE_WIDTH = 5,
  parameter int DATA_W        = 64
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [N_REQ-1:0]                req_valid_i,
  input  logic [N_REQ*REGFILE_WIDTH-1:0]  req_addr_i,
  input  logic [N_REQ*DATA_W-1:0]         req_data_i,
  output logic [N_REQ-1:0]                req_ready_o,
  input  logic                            stall_i,
  output logic                            wr_en_o,
  output logic [REGFILE_WIDTH-1:0]        wr_addr_o,
  output logic [DATA_W-1:0]               wr_data_o,
  output logic [31:0]                     pend_mask_o
);
  localparam int IDX_W = $clog2(N_REQ);

  logic [IDX_W-1:0]         rr_q, rr_d, g;
  logic                     grant;
  int                       idx_c;
  logic                     wr_en_q, wr_en_d;
  logic [REGFILE_WIDTH-1:0] wr_addr_q, wr_addr_d, g_addr;
  logic [DATA_W-1:0]        wr_data_q, wr_data_d, g_data;
  logic [N_REQ:0][31:0]     lane_mask;

  always_comb begin
    grant = 1'b0;
    g     = '0;
    idx_c = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx_c = int'(rr_q) + k;
      if (idx_c >= N_REQ) idx_c = idx_c - N_REQ;
      if (!grant && req_valid_i[idx_c] && !stall_i && !rst_i) begin
        grant = 1'b1;
        g     = IDX_W'(idx_c);
      end
    end
    req_ready_o = grant ? (N_REQ'(1) << g) : '0;
    g_addr      = req_addr_i[int'(g)*REGFILE_WIDTH +: REGFILE_WIDTH];
    g_data      = req_data_i[int'(g)*DATA_W +: DATA_W];
  end

  always_comb begin
    rr_d      = rr_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (grant) begin
      rr_d      = (g == IDX_W'(N_REQ-1)) ? '0 : g + 1'b1;
      wr_en_d   = (g_addr != '0);
      wr_addr_d = g_addr;
      wr_data_d = g_data;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q      <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      rr_q      <= rr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign wr_en_o   = wr_en_q;
  assign wr_addr_o = wr_addr_q;
  assign wr_data_o = wr_data_q;

  // Lanes 0..N_REQ-1 track waiting requests; the extra lane tracks the in-flight write.
  for (genvar i = 0; i < N_REQ; i++) begin : g_lane
    regfile_wb_pend_lane #(.REGFILE_WIDTH(REGFILE_WIDTH)) u_lane (
      .valid_i (req_valid_i[i]),
      .addr_i  (req_addr_i[i*REGFILE_WIDTH +: REGFILE_WIDTH]),
      .mask_o  (lane_mask[i])
    );
  end

  regfile_wb_pend_lane #(.REGFILE_WIDTH(REGFILE_WIDTH)) u_wr_lane (
    .valid_i (wr_en_q),
    .addr_i  (wr_addr_q),
    .mask_o  (lane_mask[N_REQ])
  );

  always_comb begin
    pend_mask_o = '0;
    for (int i = 0; i <= N_REQ; i++) pend_mask_o = pend_mask_o | lane_mask[i];
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, single grant, RR fairness, x0, stall, same-address and reset drop.
module tb_regfile_wb_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req_valid;
  logic [14:0] req_addr;
  logic [191:0] req_data;
  logic [2:0]  req_ready;
  logic        stall;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [63:0] wr_data;
  logic [31:0] pend_mask;
  int n_cmp = 0;
  int n_fail = 0;

  regfile_wb_arbiter #(.N_REQ(3), .REGFILE_WIDTH(5), .DATA_W(64)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_addr_i(req_addr),
    .req_data_i(req_data), .req_ready_o(req_ready), .stall_i(stall),
    .wr_en_o(wr_en), .wr_addr_o(wr_addr), .wr_data_o(wr_data), .pend_mask_o(pend_mask)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [2:0] v, input logic [4:0] a0, a1, a2,
                       input logic [63:0] d0, d1, d2);
    req_valid = v;
    req_addr  = {a2, a1, a0};
    req_data  = {d2, d1, d0};
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = 1'b0;
    drive(3'b000, 5'd0, 5'd0, 5'd0, 64'h0, 64'h0, 64'h0);
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0;
    drive(3'b111, 5'd1, 5'd2, 5'd3, 64'h11, 64'h22, 64'h33);
    for (int c = 0; c < 2; c++) begin
      #1;
      n_cmp++; if (req_ready !== 3'b000) begin n_fail++; $display("FAIL reset_ready: got %b exp 000", req_ready); end
      n_cmp++; if (pend_mask !== 32'h0000_000E) begin n_fail++; $display("FAIL reset_pend: got %h exp 0000000e", pend_mask); end
      tick();
      n_cmp++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %b exp 0", wr_en); end
    end
    n_cmp++; if (wr_addr !== 5'd0 || wr_data !== 64'h0) begin n_fail++; $display("FAIL reset_wr_bus: got %0d/%h exp 0/0", wr_addr, wr_data); end
    n_cmp++; if (dut.rr_q !== 2'd0) begin n_fail++; $display("FAIL reset_rr: got %0d exp 0", dut.rr_q); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    drive(3'b010, 5'd0, 5'd5, 5'd0, 64'h0, 64'hDEAD, 64'h0);
    #1;
    n_cmp++; if (req_ready !== 3'b010) begin n_fail++; $display("FAIL single_ready: got %b exp 010", req_ready); end
    n_cmp++; if (pend_mask !== 32'h0000_0020) begin n_fail++; $display("FAIL single_pend: got %h exp 00000020", pend_mask); end
    tick();
    drive(3'b000, 5'd0, 5'd0, 5'd0, 64'h0, 64'h0, 64'h0);
    n_cmp++; if (wr_en !== 1'b1 || wr_addr !== 5'd5 || wr_data !== 64'hDEAD)
      begin n_fail++; $display("FAIL single_wr: got en=%b addr=%0d data=%h exp 1/5/dead", wr_en, wr_addr, wr_data); end
    n_cmp++; if (dut.rr_q !== 2'd2) begin n_fail++; $display("FAIL single_rr: got %0d exp 2", dut.rr_q); end
    #1;
    n_cmp++; if (pend_mask !== 32'h0000_0020) begin n_fail++; $display("FAIL inflight_pend: got %h exp 00000020", pend_mask); end
    tick();
    n_cmp++; if (wr_en !== 1'b0 || wr_addr !== 5'd5) begin n_fail++; $display("FAIL single_idle: got en=%b addr=%0d exp 0/5", wr_en, wr_addr); end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_rdy [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    logic [4:0] exp_ad  [6] = '{5'd1, 5'd2, 5'd3, 5'd1, 5'd2, 5'd3};
    do_reset();
    drive(3'b111, 5'd1, 5'd2, 5'd3, 64'hA1, 64'hA2, 64'hA3);
    for (int c = 0; c < 6; c++) begin
      #1;
      n_cmp++; if (req_ready !== exp_rdy[c]) begin n_fail++; $display("FAIL rr_ready[%0d]: got %b exp %b", c, req_ready, exp_rdy[c]); end
      tick();
      n_cmp++; if (wr_en !== 1'b1 || wr_addr !== exp_ad[c]) begin n_fail++; $display("FAIL rr_wr[%0d]: got en=%b addr=%0d exp 1/%0d", c, wr_en, wr_addr, exp_ad[c]); end
    end
    n_cmp++; if (wr_data !== 64'hA3) begin n_fail++; $display("FAIL rr_data: got %h exp a3", wr_data); end
  endtask

  task automatic test_x0();
    do_reset();
    drive(3'b001, 5'd0, 5'd0, 5'd0, 64'hFF, 64'h0, 64'h0);
    #1;
    n_cmp++; if (req_ready !== 3'b001) begin n_fail++; $display("FAIL x0_ready: got %b exp 001", req_ready); end
    n_cmp++; if (pend_mask !== 32'h0) begin n_fail++; $display("FAIL x0_pend: got %h exp 00000000", pend_mask); end
    tick();
    n_cmp++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL x0_wr_en: got %b exp 0", wr_en); end
    n_cmp++; if (dut.rr_q !== 2'd1) begin n_fail++; $display("FAIL x0_rr: got %0d exp 1", dut.rr_q); end
  endtask

  task automatic test_stall();
    // follows test_x0, so the pointer sits at 1
    drive(3'b111, 5'd1, 5'd2, 5'd3, 64'hB1, 64'hB2, 64'hB3);
    stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++; if (req_ready !== 3'b000) begin n_fail++; $display("FAIL stall_ready[%0d]: got %b exp 000", c, req_ready); end
      tick();
      n_cmp++; if (wr_en !== 1'b0 || dut.rr_q !== 2'd1) begin n_fail++; $display("FAIL stall_hold[%0d]: got en=%b rr=%0d exp 0/1", c, wr_en, dut.rr_q); end
    end
    stall = 1'b0;
    #1;
    n_cmp++; if (req_ready !== 3'b010) begin n_fail++; $display("FAIL stall_release: got %b exp 010", req_ready); end
    tick();
    n_cmp++; if (wr_addr !== 5'd2 || wr_data !== 64'hB2) begin n_fail++; $display("FAIL stall_wr: got %0d/%h exp 2/b2", wr_addr, wr_data); end
  endtask

  task automatic test_same_addr();
    do_reset();
    drive(3'b101, 5'd7, 5'd0, 5'd7, 64'hAAAA, 64'h0, 64'hBBBB);
    #1;
    n_cmp++; if (req_ready !== 3'b001) begin n_fail++; $display("FAIL same_ready0: got %b exp 001", req_ready); end
    tick();
    drive(3'b100, 5'd7, 5'd0, 5'd7, 64'hAAAA, 64'h0, 64'hBBBB);
    n_cmp++; if (wr_data !== 64'hAAAA || wr_addr !== 5'd7) begin n_fail++; $display("FAIL same_first: got %0d/%h exp 7/aaaa", wr_addr, wr_data); end
    #1;
    n_cmp++; if (req_ready !== 3'b100) begin n_fail++; $display("FAIL same_ready2: got %b exp 100", req_ready); end
    tick();
    n_cmp++; if (wr_en !== 1'b1 || wr_data !== 64'hBBBB) begin n_fail++; $display("FAIL same_second: got en=%b data=%h exp 1/bbbb", wr_en, wr_data); end
    drive(3'b000, 5'd0, 5'd0, 5'd0, 64'h0, 64'h0, 64'h0);
  endtask

  task automatic test_reset_drop();
    do_reset();
    drive(3'b101, 5'd7, 5'd0, 5'd7, 64'hAAAA, 64'h0, 64'hBBBB);
    tick();
    drive(3'b100, 5'd7, 5'd0, 5'd7, 64'hAAAA, 64'h0, 64'hBBBB);
    rst = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 3'b000) begin n_fail++; $display("FAIL drop_ready: got %b exp 000", req_ready); end
    n_cmp++; if (pend_mask !== 32'h0000_0080) begin n_fail++; $display("FAIL drop_pend: got %h exp 00000080", pend_mask); end
    tick();
    rst = 1'b0;
    drive(3'b000, 5'd0, 5'd0, 5'd0, 64'h0, 64'h0, 64'h0);
    n_cmp++; if (wr_en !== 1'b0 || wr_data !== 64'h0 || dut.rr_q !== 2'd0)
      begin n_fail++; $display("FAIL drop_state: got en=%b data=%h rr=%0d exp 0/0/0", wr_en, wr_data, dut.rr_q); end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0;
    drive(3'b000, 5'd0, 5'd0, 5'd0, 64'h0, 64'h0, 64'h0);
    test_reset();
    test_single();
    test_round_robin();
    test_x0();
    test_stall();
    test_same_addr();
    test_reset_drop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
